// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: 4-source AXI-Stream round-robin arbiter, packet-locked grant.
// Optional AXIS_ARB_PKT_CNT_EN adds per-source 16-bit packet counters on pkt_cnt.
module axis_rr_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_SRC    = 4
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   input  logic [2*NUM_SRC-1:0]          s_axis_tdest,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   output logic [1:0]                    m_axis_tdest,
   input  logic                          m_axis_tready,
   output logic [1:0]                    m_axis_tid,
`ifdef AXIS_ARB_PKT_CNT_EN
   output logic [63:0]                   pkt_cnt,
`endif
   output logic                          busy
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t                state;
   logic [1:0]            grant;
   logic [1:0]            last_grant;
   logic [1:0]            pick;
   logic                  g_valid;
   logic                  g_last;
   logic [DATA_WIDTH-1:0] g_data;
   logic [1:0]            g_dest;
   logic                  load_ok;
   logic                  s_fire;
   logic                  pkt_end;

   // Round-robin search starting one past the previous winner.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_grant + 2'(k);
         if (!found && s_axis_tvalid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // Select the granted source's stream fields.
   always_comb begin
      g_valid = s_axis_tvalid[grant];
      g_last  = s_axis_tlast[grant];
      g_data  = s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
      g_dest  = s_axis_tdest[grant*2 +: 2];
   end

   // The output register can take a beat when empty or draining this cycle.
   always_comb begin
      load_ok       = aresetn && (state == LOCK) &&
                      (!m_axis_tvalid || m_axis_tready);
      s_axis_tready = '0;
      if (load_ok)
         s_axis_tready = NUM_SRC'(1) << grant;
      s_fire  = load_ok && g_valid;
      pkt_end = s_fire && g_last;
   end

   // Arbitration FSM: one IDLE cycle picks a source, LOCK holds it to tlast.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= 2'd3;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|s_axis_tvalid) begin
                  grant <= pick;
                  state <= LOCK;
                  busy  <= 1'b1;
               end
            end
            LOCK: begin
               if (pkt_end) begin
                  last_grant <= grant;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Single output register stage; load and unload may overlap.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdest  <= '0;
         m_axis_tid    <= '0;
      end else if (s_fire) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= g_data;
         m_axis_tlast  <= g_last;
         m_axis_tdest  <= g_dest;
         m_axis_tid    <= grant;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

`ifdef AXIS_ARB_PKT_CNT_EN
   // Count accepted end-of-packet beats per source, wrapping at 16 bits.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         pkt_cnt <= '0;
      end else if (pkt_end) begin
         pkt_cnt[grant*16 +: 16] <= pkt_cnt[grant*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the tdata width of every stream.
REQ-002 SHALL have parameter NUM_SRC, fixed at 4, meaning the number of requesting AXI-Stream slaves; the source index is 2 bits wide.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port s_axis_tdata, input, 4*DATA_WIDTH bits: source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have ports s_axis_tvalid, s_axis_tlast and s_axis_tready, 4 bits each (tready is the only output of the three), one bit per source.
REQ-007 SHALL have port s_axis_tdest, input, 8 bits: source i occupies bits [2i+1:2i].
REQ-008 SHALL have ports m_axis_tdata (DATA_WIDTH bits), m_axis_tvalid (1), m_axis_tlast (1) and m_axis_tdest (2) as outputs, and m_axis_tready (1) as an input.
REQ-009 SHALL have port m_axis_tid, output, 2 bits: the index of the source that owns the current output beat.
REQ-010 SHALL have port busy, output, 1 bit: high while the FSM is in the LOCK state.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and LOCK.
REQ-012 In IDLE with any s_axis_tvalid set, SHALL grant the first valid source searching (last_grant+1) mod 4 upward, wrapping, and go to LOCK at the next edge.
REQ-013 In IDLE with no source valid, SHALL stay in IDLE with all s_axis_tready low.
REQ-014 s_axis_tready[g] SHALL equal (state==LOCK) && (!m_axis_tvalid || m_axis_tready) for the granted source g; every other tready bit SHALL be 0.
REQ-015 The output SHALL be a single register stage loaded on each source handshake: tdata, tlast and tdest copied from source g, tid=g; output latency is 1 cycle.
REQ-016 m_axis_tvalid SHALL clear on an output handshake that has no simultaneous new load, and SHALL stay set if a load and an unload happen in the same cycle; this gives full throughput of one beat per cycle.
REQ-017 While m_axis_tvalid is set and m_axis_tready is low, all m_axis_* outputs SHALL hold stable.
REQ-018 A source handshake with tlast=1 SHALL set last_grant=g and return the FSM to IDLE at the same edge; grant is packet-locked and never switches mid-packet.
REQ-019 Each new arbitration SHALL cost exactly one IDLE cycle between packets.
REQ-020 A granted source dropping tvalid mid-packet SHALL keep the grant indefinitely; the block has no timeout.
REQ-021 A single-beat packet (tlast on the first beat) SHALL be handled by rules REQ-018 and REQ-019 with no special case.
REQ-022 A source whose tvalid rises while another source holds the grant SHALL wait until the next IDLE cycle.

Reset
REQ-023 With aresetn low at a rising edge, the block SHALL go to state IDLE, last_grant=3 (so source 0 wins first), m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tdest=0, m_axis_tid=0, busy=0 and all s_axis_tready=0.
REQ-024 Reset asserted mid-packet SHALL discard the held output beat and the grant with no drain.
REQ-025 All s_axis_tready bits SHALL be low during reset.

Configuration
REQ-026 Macro AXIS_ARB_PKT_CNT_EN, when defined, SHALL add output pkt_cnt, 64 bits, made of four 16-bit counters (source i at [16i +: 16]).
REQ-027 Each pkt_cnt counter SHALL increment by 1 on an accepted tlast beat from its source and wrap from 0xFFFF to 0, with reset value 0.
REQ-028 Without the macro, the pkt_cnt port and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then only source 2 sends a 3-beat packet (tdata 0xA0, 0xA1, 0xA2, tdest=1) with m_axis_tready=1 -> the output carries those 3 beats with tid=2 and tdest=1, the first beat appearing 2 cycles after tvalid rises, and tlast is set on 0xA2 only.
REQ-030 All four sources hold 1-beat packets continuously -> output tid sequence is 0, 1, 2, 3, 0, with one beat every 2 cycles.
REQ-031 Source 0 sends a 4-beat packet while m_axis_tready toggles 1, 0, 0, 1, ... -> no beat is lost or duplicated, outputs hold stable while stalled, and s_axis_tready[0] is low on stalled cycles.
REQ-032 Source 1 is mid-packet and source 3 raises tvalid -> s_axis_tready[3] stays 0 until source 1's tlast handshake, then source 3 is granted after one IDLE cycle.
REQ-033 aresetn is asserted for 1 cycle after beat 2 of a 5-beat packet -> the next cycle shows m_axis_tvalid=0 and busy=0, and a fresh request from source 0 is granted first.
REQ-034 With AXIS_ARB_PKT_CNT_EN defined, source 1 sends 65537 single-beat packets -> pkt_cnt[31:16] reads 1.
